md_sequencer: RTL

Sequencer for the shared 32-cycle multiply/divide unit. Accepts a one-cycle start request from the main control FSM, holds the unit's `multOp`/`divOp` enable for exactly `CYCLES` clocks, then pulses `StoreMD` so the HI/LO result is latched. It sits between the control unit/ALU control decoder and the mult/div datapath, and supplies the busy/done handshake that the control FSM stalls on.

---
 rtl/md_sequencer.sv | 126 ++++++++++++
 1 files changed

// File: rtl/md_sequencer.sv
// md_sequencer: sequencer for the shared multi-cycle multiply/divide unit.
// Accepts a one-cycle start request, holds multOp/divOp for CYCLES clocks,
// then pulses StoreMD/done so the HI/LO result is latched. busy covers the
// whole operation so the control FSM can stall on it.
//
// Optional feature macro: MD_DIVZERO_CHECK_EN
//   defined     -> a divide started with divisor_zero=1 takes the ERR path and
//                  raises a one-cycle div_zero pulse instead of running.
//   not defined -> divisor_zero is ignored, ERR is unreachable, div_zero is 0.
module md_sequencer #(
    parameter int CYCLES = 32,  // enable-high cycles per operation, 2..2**CNT_W
    parameter int CNT_W  = 5    // iteration counter width
) (
    input  logic       clk,
    input  logic       reset,         // asynchronous, active-low
    input  logic       start,
    input  logic       op,            // 0 = multiply, 1 = divide
    input  logic       divisor_zero,
    input  logic       abort,
    output logic       multOp,
    output logic       divOp,
    output logic [1:0] StoreMD,       // 2'b01 divide, 2'b10 multiply
    output logic       busy,
    output logic       done,
    output logic       div_zero
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        STORE = 2'd2,
        ERR   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             op_q;
    logic             zero_err;

    // Decide at accept time whether this request is a divide-by-zero.
`ifdef MD_DIVZERO_CHECK_EN
    assign zero_err = op & divisor_zero;
`else
    logic unused_divisor_zero;
    assign unused_divisor_zero = divisor_zero;
    assign zero_err            = 1'b0;
`endif

    // Sequencer FSM: state, iteration counter and all registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            op_q     <= 1'b0;
            multOp   <= 1'b0;
            divOp    <= 1'b0;
            StoreMD  <= 2'b00;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            // NOTE: pulse outputs default low every edge with non-blocking
            // assignments; a later assignment in the same block overrides it,
            // so each pulse lasts exactly one cycle.
            StoreMD  <= 2'b00;
            done     <= 1'b0;
            div_zero <= 1'b0;

            if (abort) begin
                // Cancel wins over everything, including a same-cycle start.
                state  <= IDLE;
                multOp <= 1'b0;
                divOp  <= 1'b0;
                busy   <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start) begin
                            op_q <= op;
                            busy <= 1'b1;
                            if (zero_err) begin
                                state    <= ERR;
                                div_zero <= 1'b1;
                            end else begin
                                state  <= RUN;
                                cnt    <= CNT_LOAD;
                                multOp <= ~op;
                                divOp  <= op;
                            end
                        end
                    end

                    RUN: begin
                        if (cnt == '0) begin
                            state   <= STORE;
                            multOp  <= 1'b0;
                            divOp   <= 1'b0;
                            StoreMD <= op_q ? 2'b01 : 2'b10;
                            done    <= 1'b1;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end

                    STORE: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end

                    ERR: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end

                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
